// File: rtl/seq_mac_multiplier.sv
// Iterative shift-add multiply-accumulate unit: one N x N multiply every N+3 cycles,
// with signed/unsigned operands, start/busy/done handshake and a sticky-overflow accumulator.
module seq_mac_multiplier #(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 2 * N + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic             signed_mode,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   out,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       mcand_q, mplier_q;
  logic [2*N:0]       pp_q;
  logic [CW-1:0]      cnt_q;
  logic               sign_q, smode_q, acc_en_q;
  logic [2*N-1:0]     out_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ov_q;

  logic [N-1:0]       x_mag, y_mag;
  logic [N:0]         upper_sum;
  logic [2*N:0]       pp_step;
  logic [2*N-1:0]     product;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     acc_sum;
  logic               ovf_now;

  // -2^(N-1) negates to itself, which reads correctly as the unsigned magnitude 2^(N-1)
  assign x_mag = (signed_mode && x[N-1]) ? (~x + N'(1)) : x;
  assign y_mag = (signed_mode && y[N-1]) ? (~y + N'(1)) : y;

  assign upper_sum = pp_q[2*N:N] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign pp_step   = {upper_sum, pp_q[N-1:0]} >> 1;

  assign product  = sign_q ? (~pp_q[2*N-1:0] + (2*N)'(1)) : pp_q[2*N-1:0];
  assign prod_ext = smode_q ? ACC_W'($signed(product)) : ACC_W'(product);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, prod_ext};
  assign ovf_now  = smode_q ? ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                               (acc_sum[ACC_W-1] != acc_q[ACC_W-1]))
                            : acc_sum[ACC_W];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (cnt_q == CW'(N - 1)) state_d = StSign;
      StSign:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      pp_q     <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      smode_q  <= 1'b0;
      acc_en_q <= 1'b0;
      out_q    <= '0;
      acc_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        if (acc_clr) begin
          acc_q <= '0;
          ov_q  <= 1'b0;
        end
        if (start) begin
          mcand_q  <= x_mag;
          mplier_q <= y_mag;
          sign_q   <= signed_mode & (x[N-1] ^ y[N-1]);
          smode_q  <= signed_mode;
          acc_en_q <= acc_en;
          pp_q     <= '0;
          cnt_q    <= '0;
        end
      end else if (state_q == StCalc) begin
        pp_q     <= pp_step;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
      end else if (state_q == StSign) begin
        out_q <= product;
        if (acc_en_q) begin
          acc_q <= acc_sum[ACC_W-1:0];
          ov_q  <= ov_q | ovf_now;
        end
      end
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign out      = out_q;
  assign acc_out  = acc_q;
  assign overflow = ov_q;

endmodule

// File: tb/tb_seq_mac_multiplier.sv
// Directed self-checking bench for seq_mac_multiplier at N=8, ACC_W=20.
module tb_seq_mac_multiplier;

  localparam int N     = 8;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [N-1:0]     x = '0;
  logic [N-1:0]     y = '0;
  logic             signed_mode = 1'b0;
  logic             acc_en = 1'b0;
  logic             acc_clr = 1'b0;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   out;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;

  int tests = 0;
  int fails = 0;

  seq_mac_multiplier #(.N(N), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x          (x),
    .y          (y),
    .signed_mode(signed_mode),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr),
    .busy       (busy),
    .done       (done),
    .out        (out),
    .acc_out    (acc_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Runs one operation; lat = negedge samples from the start edge until done is seen,
  // bcnt = samples with busy high, dafter = done one sample after the pulse.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm,
                       input logic ae, input logic clr, output logic [2*N-1:0] o,
                       output int lat, output int bcnt, output logic dafter);
    @(negedge clk);
    x = a; y = b; signed_mode = sm; acc_en = ae; acc_clr = clr; start = 1'b1;
    @(negedge clk);
    start = 1'b0; acc_clr = 1'b0;
    x = 8'h5A; y = 8'hA5; signed_mode = ~sm; acc_en = ~ae;
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL op_timeout: done=%0b after %0d cycles, required 1", done, lat);
    end
    o = out;
    @(negedge clk);
    if (busy) bcnt++;
    dafter = done;
  endtask

  task automatic test_reset();
    int dcnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b want 0", done); end
    tests++; if (out !== 16'h0) begin fails++; $display("FAIL rst_out: got %h want 0", out); end
    tests++;
    if (acc_out !== 20'h0 || overflow !== 1'b0) begin
      fails++; $display("FAIL rst_acc: got %h/%0b want 0/0", acc_out, overflow);
    end
    // Reset in the middle of CALC
    @(negedge clk);
    x = 8'd5; y = 8'd3; signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %0b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0 || acc_out !== 20'h0 || overflow !== 1'b0)
    begin
      fails++;
      $display("FAIL mid_rst: busy=%0b done=%0b out=%h acc=%h ov=%0b want all 0",
               busy, done, out, acc_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    tests++;
    if (dcnt != 0 || out !== 16'h0 || acc_out !== 20'h0) begin
      fails++; $display("FAIL rst_discard: dones=%0d out=%h acc=%h want 0/0/0", dcnt, out, acc_out);
    end
  endtask

  task automatic test_signed_basic();
    logic [2*N-1:0] o; int lat, bcnt; logic da;
    do_op(8'hF9, 8'd6, 1'b1, 1'b0, 1'b0, o, lat, bcnt, da);
    tests++; if (o !== 16'hFFD6) begin fails++; $display("FAIL sb_out: got %h want ffd6", o); end
    tests++; if (lat != 10) begin fails++; $display("FAIL sb_latency: got %0d want 10", lat); end
    tests++; if (da !== 1'b0) begin fails++; $display("FAIL sb_done_width: got %0b want 0", da); end
    tests++; if (bcnt != 10) begin fails++; $display("FAIL sb_busy_cycles: got %0d want 10", bcnt); end
    tests++; if (acc_out !== 20'h0) begin fails++; $display("FAIL sb_acc: got %h want 0", acc_out); end
  endtask

  task automatic test_corners();
    logic [2*N-1:0] o; int lat, bcnt; logic da;
    do_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, o, lat, bcnt, da);
    tests++; if (o !== 16'h4000) begin fails++; $display("FAIL c_min_min: got %h want 4000", o); end
    do_op(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, o, lat, bcnt, da);
    tests++; if (o !== 16'hC080) begin fails++; $display("FAIL c_min_max: got %h want c080", o); end
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, o, lat, bcnt, da);
    tests++; if (o !== 16'hFE01) begin fails++; $display("FAIL c_u_ff: got %h want fe01", o); end
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, o, lat, bcnt, da);
    tests++; if (o !== 16'h0001) begin fails++; $display("FAIL c_s_m1m1: got %h want 0001", o); end
  endtask

  task automatic test_accumulate();
    logic [2*N-1:0] o; int lat, bcnt; logic da;
    do_op(8'd10, 8'd10, 1'b1, 1'b1, 1'b1, o, lat, bcnt, da);
    tests++; if (acc_out !== 20'd100) begin fails++; $display("FAIL acc1: got %h want 00064", acc_out); end
    do_op(8'hFD, 8'd4, 1'b1, 1'b1, 1'b0, o, lat, bcnt, da);
    tests++; if (acc_out !== 20'd88) begin fails++; $display("FAIL acc2: got %h want 00058", acc_out); end
    do_op(8'h9C, 8'd2, 1'b1, 1'b1, 1'b0, o, lat, bcnt, da);
    tests++;
    if (acc_out !== 20'hFFF90 || overflow !== 1'b0) begin
      fails++; $display("FAIL acc3: got %h/%0b want fff90/0", acc_out, overflow);
    end
  endtask

  task automatic test_overflow();
    logic [2*N-1:0] o; int lat, bcnt; logic da;
    logic [ACC_W-1:0] exp17;
    exp17 = ACC_W'((17 * 65025) % (1 << ACC_W));
    for (int i = 0; i < 16; i++) do_op(8'hFF, 8'hFF, 1'b0, 1'b1, (i == 0), o, lat, bcnt, da);
    tests++;
    if (acc_out !== 20'd1040400 || overflow !== 1'b0) begin
      fails++; $display("FAIL ov_16: got %0d/%0b want 1040400/0", acc_out, overflow);
    end
    do_op(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, o, lat, bcnt, da);
    tests++;
    if (acc_out !== exp17 || overflow !== 1'b1) begin
      fails++; $display("FAIL ov_17: got %0d/%0b want %0d/1", acc_out, overflow, exp17);
    end
    do_op(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, o, lat, bcnt, da);
    tests++;
    if (acc_out !== 20'd121874 || overflow !== 1'b1) begin
      fails++; $display("FAIL ov_sticky: got %0d/%0b want 121874/1", acc_out, overflow);
    end
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    tests++;
    if (acc_out !== 20'h0 || overflow !== 1'b0) begin
      fails++; $display("FAIL ov_clr: got %h/%0b want 0/0", acc_out, overflow);
    end
  endtask

  task automatic test_handshake();
    int lat, dcnt;
    @(negedge clk);
    x = 8'd3; y = 8'd7; signed_mode = 1'b0; acc_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; dcnt = 0;
    while (lat < 30) begin
      // Stray starts mid-calc, during SIGN and during the DONE cycle
      if (lat == 3 || lat == 9 || lat == 10) begin x = 8'd9; y = 8'd11; start = 1'b1; end
      else begin start = 1'b0; x = 8'd0; y = 8'd0; end
      if (done) dcnt++;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    tests++; if (dcnt != 1) begin fails++; $display("FAIL hs_done_count: got %0d want 1", dcnt); end
    tests++; if (out !== 16'd21) begin fails++; $display("FAIL hs_out: got %0d want 21", out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hs_idle: got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] o; int lat, bcnt; logic da;
    do_op(8'd10, 8'd10, 1'b1, 1'b1, 1'b0, o, lat, bcnt, da);
    tests++;
    if (acc_out == 20'h0) begin fails++; $display("FAIL b2b_pre: got %h want nonzero", acc_out); end
    do_op(8'd4, 8'd5, 1'b1, 1'b1, 1'b1, o, lat, bcnt, da);
    tests++;
    if (acc_out !== 20'd20 || o !== 16'd20) begin
      fails++; $display("FAIL b2b_clr_start: acc=%0d out=%0d want 20/20", acc_out, o);
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_corners();
    test_accumulate();
    test_overflow();
    test_handshake();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
